position_cursor: RTL and testbench
==================================

Name: position_cursor

Overview:
- Parametrised successor to the 4-to-16 position decoder.
- Holds a registered cursor on a ROWS x COLS grid. Moves it by directional strobes or a direct index load, with wrap or saturate at the edges.
- Emits the enable-gated one-hot position vector (bit k = cell k) and keeps a per-cell occupied mask.
- Sits between the user-input debouncer/FSM and the cell-drive logic of the board display.

Parameters:
- ROWS, 4, grid rows (>=1).
- COLS, 4, grid columns (>=1).
- WRAP, 1, 1 = moves wrap at the grid edge; 0 = moves saturate at the edge.
- BLINK_DIV, 8, clock cycles per blink half-period (used only with the optional feature; >=1).
- Derived, not overridable: N = ROWS*COLS; IDX_W = max(1, $clog2(N)).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  output gate for out_en.
- mv_left  in  1  move one column left (strobe).
- mv_right  in  1  move one column right (strobe).
- mv_up  in  1  move one row up, toward row 0 (strobe).
- mv_down  in  1  move one row down (strobe).
- load  in  1  load cursor from load_idx (strobe).
- load_idx  in  IDX_W  target cell index, row-major.
- mark  in  1  set occupied bit of the current cell (strobe).
- clear_all  in  1  clear the entire occupied mask (strobe).
- pos_idx  out  IDX_W  current cursor index = row*COLS + col.
- out_en  out  N  one-hot cursor vector, gated by enable.
- occ  out  N  occupied mask.
- full  out  1  high when all N occ bits are set.
- err  out  1  one-cycle error pulse.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Cursor state:
  - row and col registers; pos_idx is computed combinationally from them.
  - On rst: row = 0, col = 0, occ = 0, err = 0. Therefore pos_idx = 0 and full = 0.
  - out_en after reset = 1 (one-hot cell 0) if enable is high, else 0.
- Per-clock priority (rst highest):
  1. rst.
  2. load.
  3. Moves. Exactly one mv_* high takes effect. Zero or two or more mv_* high: cursor holds, no error.
- load:
  - If load_idx < N: row = load_idx / COLS, col = load_idx % COLS.
  - Else: cursor holds and err pulses.
  - Moves asserted in the same cycle are ignored.
- Moves, WRAP=1:
  - left at col 0 goes to col COLS-1; right at col COLS-1 goes to col 0.
  - up at row 0 goes to row ROWS-1; down at row ROWS-1 goes to row 0.
  - Row/column is never carried into the other axis.
- Moves, WRAP=0: the coordinate holds at the edge, no error.
- Degenerate sizes: COLS=1 makes left/right no-ops; ROWS=1 makes up/down no-ops.
- Latency: a move or load is visible on pos_idx and out_en the cycle after the strobe's clock edge.
- out_en:
  - Combinational from registered pos_idx: out_en = enable ? (1 << pos_idx) : 0.
  - No other bit pattern is ever driven.
- mark:
  - Acts on the cursor position before any same-cycle update.
  - If occ[pos] = 0, set it. If occ[pos] = 1, occ is unchanged and err pulses.
- clear_all:
  - occ goes to 0 next cycle.
  - clear_all together with mark: clear_all wins, and no err from that mark.
- full is combinational AND of occ.
- err:
  - Registered and high for exactly one cycle per offending cycle.
  - Back-to-back errors give back-to-back pulses.
- rst asserted mid-operation overrides every strobe in that cycle.

Optional Feature:
- Macro: POSITION_CURSOR_BLINK_EN.
- When defined:
  - A blink counter (width $clog2(BLINK_DIV)+1) toggles a blink phase every BLINK_DIV cycles.
  - out_en = (enable & phase) ? onehot : 0.
  - rst sets counter = 0 and phase = 1.
  - Any successful move or load restarts the counter with phase = 1, so the cursor shows immediately.
- When undefined: no counter is instantiated; out_en is as described above.

Test Plan:
- Reset with enable=1, ROWS=COLS=4 -> pos_idx=0, out_en=16'h0001, occ=0, full=0, err=0.
- WRAP=1, load 3 then mv_right -> pos_idx=0; load 12 then mv_down -> pos_idx=0; mv_left from 0 -> pos_idx=3.
- WRAP=0, load 15 then mv_right and mv_down -> pos_idx stays 15, no err; load 0, mv_up -> stays 0.
- load_idx=9 -> out_en=16'h0200 next cycle. With ROWS=3, COLS=5, load_idx=15 -> pos unchanged, err high one cycle. mv_left+mv_right together -> no move.
- mark at 5 twice -> occ=16'h0020, second mark gives err pulse. mark every cell -> full=1. clear_all+mark same cycle -> occ=0, err=0.
- With POSITION_CURSOR_BLINK_EN, BLINK_DIV=4 -> out_en alternates on 4 cycles / off 4 cycles. A move mid-off-phase -> out_en on the next cycle. enable=0 -> out_en=0 always.

Source files
------------

// File: rtl/position_cursor.sv
// position_cursor
//   Registered cursor on a ROWS x COLS grid, row-major cell numbering.
//   The cursor moves with single-step directional strobes or jumps with a
//   direct index load. Moves either wrap or saturate at the grid edge (WRAP).
//   Drives an enable-gated one-hot cursor vector and keeps a per-cell
//   occupied mask that is set by mark and cleared by clear_all.
//
//   Optional feature macro: POSITION_CURSOR_BLINK_EN
//     When defined, out_en is additionally gated by a blink phase that
//     toggles every BLINK_DIV cycles. The phase restarts "on" after reset
//     and after every cursor move or load that takes effect.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   enable     output gate for out_en
//   mv_left/mv_right/mv_up/mv_down  single-step move strobes
//   load       load cursor from load_idx (strobe)
//   load_idx   target cell index, row-major
//   mark       set occupied bit of the current cell (strobe)
//   clear_all  clear the whole occupied mask (strobe)
//   pos_idx    current cursor index = row*COLS + col
//   out_en     one-hot cursor vector, gated by enable
//   occ        occupied mask
//   full       all occupied bits set
//   err        one-cycle error pulse (bad load index or re-mark)
module position_cursor #(
  parameter  int ROWS      = 4,
  parameter  int COLS      = 4,
  parameter  int WRAP      = 1,
  parameter  int BLINK_DIV = 8,
  localparam int N         = ROWS * COLS,
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mv_left,
  input  logic             mv_right,
  input  logic             mv_up,
  input  logic             mv_down,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic             mark,
  input  logic             clear_all,
  output logic [IDX_W-1:0] pos_idx,
  output logic [N-1:0]     out_en,
  output logic [N-1:0]     occ,
  output logic             full,
  output logic             err
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);
  // One extra bit so that N and COLS are representable even when N is a
  // power of two (e.g. ROWS=1 makes COLS == N == 2**IDX_W).
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);
  localparam logic [IDX_W:0]   COLS_EXT = (IDX_W + 1)'(COLS);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [N-1:0]     occ_q, occ_d;
  logic             err_q, err_d;

  logic [IDX_W:0]   pos_ext;
  logic [IDX_W:0]   load_ext;
  logic [IDX_W:0]   load_row_ext;
  logic [IDX_W:0]   load_col_ext;
  logic             load_ok;
  logic [2:0]       mv_cnt;
  logic             mv_one;
  logic             mark_dup;
  logic [N-1:0]     onehot;

  always_comb begin
    pos_ext = (IDX_W + 1)'(row_q) * COLS_EXT + (IDX_W + 1)'(col_q);
  end
  assign pos_idx = pos_ext[IDX_W-1:0];

  always_comb begin
    onehot          = '0;
    onehot[pos_idx] = 1'b1;
  end

  always_comb begin
    load_ext     = {1'b0, load_idx};
    load_ok      = (load_ext < N_EXT);
    load_row_ext = load_ext / COLS_EXT;
    load_col_ext = load_ext % COLS_EXT;
  end

  // A move only counts when exactly one direction strobe is high.
  assign mv_cnt = 3'(mv_left) + 3'(mv_right) + 3'(mv_up) + 3'(mv_down);
  assign mv_one = (mv_cnt == 3'd1);

  // mark looks at the cursor as registered, i.e. before this cycle's move.
  assign mark_dup = mark & ~clear_all & occ_q[pos_idx];

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (load) begin
      if (load_ok) begin
        row_d = load_row_ext[ROW_W-1:0];
        col_d = load_col_ext[COL_W-1:0];
      end
    end else if (mv_one) begin
      if (mv_left) begin
        if (col_q == '0) col_d = (WRAP != 0) ? COL_MAX : col_q;
        else             col_d = col_q - COL_W'(1);
      end
      if (mv_right) begin
        if (col_q == COL_MAX) col_d = (WRAP != 0) ? '0 : col_q;
        else                  col_d = col_q + COL_W'(1);
      end
      if (mv_up) begin
        if (row_q == '0) row_d = (WRAP != 0) ? ROW_MAX : row_q;
        else             row_d = row_q - ROW_W'(1);
      end
      if (mv_down) begin
        if (row_q == ROW_MAX) row_d = (WRAP != 0) ? '0 : row_q;
        else                  row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (clear_all)  occ_d = '0;
    else if (mark)  occ_d = occ_q | onehot;
  end

  assign err_d = (load & ~load_ok) | mark_dup;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  assign occ  = occ_q;
  assign full = &occ_q;
  assign err  = err_q;

`ifdef POSITION_CURSOR_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic             restart;

  // Restart the blink on any cursor update that took effect so the new
  // position is shown immediately.
  assign restart = (load & load_ok) | (~load & mv_one);

  always_comb begin
    blink_cnt_d = blink_cnt_q + CNT_W'(1);
    phase_d     = phase_q;
    if (restart) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign out_en = (enable & phase_q) ? onehot : '0;
`else
  assign out_en = enable ? onehot : '0;
`endif

endmodule

// File: tb/tb_position_cursor.sv
// Testbench for position_cursor. Three instances share one stimulus stream:
//   d=0: 4x4 wrapping, d=1: 4x4 saturating, d=2: 3x5 wrapping.
// A cell-index level reference model tracks each instance.
module tb_position_cursor;

  localparam int BDIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable, mv_left, mv_right, mv_up, mv_down, load, mark, clear_all;
  logic [3:0] load_idx;

  logic [3:0]  pos_a, pos_b, pos_c;
  logic [15:0] oe_a, oe_b, occ_a, occ_b;
  logic [14:0] oe_c, occ_c;
  logic        full_a, full_b, full_c, err_a, err_b, err_c;

  logic [3:0]  pos[3];
  logic [15:0] oe[3];
  logic [15:0] occ[3];
  logic        full[3];
  logic        err[3];

  always_comb begin
    pos[0] = pos_a;  pos[1] = pos_b;  pos[2] = pos_c;
    oe[0]  = oe_a;   oe[1]  = oe_b;   oe[2]  = {1'b0, oe_c};
    occ[0] = occ_a;  occ[1] = occ_b;  occ[2] = {1'b0, occ_c};
    full[0] = full_a; full[1] = full_b; full[2] = full_c;
    err[0]  = err_a;  err[1]  = err_b;  err[2]  = err_c;
  end

  position_cursor #(.ROWS(4), .COLS(4), .WRAP(1), .BLINK_DIV(BDIV)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .mv_left(mv_left), .mv_right(mv_right),
    .mv_up(mv_up), .mv_down(mv_down), .load(load), .load_idx(load_idx), .mark(mark),
    .clear_all(clear_all), .pos_idx(pos_a), .out_en(oe_a), .occ(occ_a), .full(full_a),
    .err(err_a));

  position_cursor #(.ROWS(4), .COLS(4), .WRAP(0), .BLINK_DIV(BDIV)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .mv_left(mv_left), .mv_right(mv_right),
    .mv_up(mv_up), .mv_down(mv_down), .load(load), .load_idx(load_idx), .mark(mark),
    .clear_all(clear_all), .pos_idx(pos_b), .out_en(oe_b), .occ(occ_b), .full(full_b),
    .err(err_b));

  position_cursor #(.ROWS(3), .COLS(5), .WRAP(1), .BLINK_DIV(BDIV)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .mv_left(mv_left), .mv_right(mv_right),
    .mv_up(mv_up), .mv_down(mv_down), .load(load), .load_idx(load_idx), .mark(mark),
    .clear_all(clear_all), .pos_idx(pos_c), .out_en(oe_c), .occ(occ_c), .full(full_c),
    .err(err_c));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cursor kept as a plain cell index.
  int          cfg_rows[3] = '{4, 4, 3};
  int          cfg_cols[3] = '{4, 4, 5};
  int          cfg_wrap[3] = '{1, 0, 1};
  int          m_idx[3];
  logic [15:0] m_occ[3];
  logic        m_err[3];
  int          m_t[3];   // cycles since reset / last effective cursor update

  function automatic logic [15:0] exp_oe(int d);
    logic on;
    on = enable;
`ifdef POSITION_CURSOR_BLINK_EN
    on = on && (((m_t[d] / BDIV) % 2) == 0);
`endif
    return on ? (16'd1 << m_idx[d]) : 16'd0;
  endfunction

  function automatic logic [15:0] full_mask(int d);
    return 16'((32'd1 << (cfg_rows[d] * cfg_cols[d])) - 1);
  endfunction

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      int n, r, c, rows, cols, nmv;
      logic e, moved;
      rows = cfg_rows[d];
      cols = cfg_cols[d];
      n = rows * cols;
      if (rst) begin
        m_idx[d] = 0; m_occ[d] = '0; m_err[d] = 1'b0; m_t[d] = 0;
        continue;
      end
      e = 1'b0;
      moved = 1'b0;
      if (clear_all)     m_occ[d] = '0;
      else if (mark) begin
        if (m_occ[d][m_idx[d]]) e = 1'b1;
        else m_occ[d][m_idx[d]] = 1'b1;
      end
      nmv = int'(mv_left) + int'(mv_right) + int'(mv_up) + int'(mv_down);
      if (load) begin
        if (int'(load_idx) < n) begin m_idx[d] = int'(load_idx); moved = 1'b1; end
        else e = 1'b1;
      end else if (nmv == 1) begin
        r = m_idx[d] / cols;
        c = m_idx[d] % cols;
        if (mv_left)  c = cfg_wrap[d] ? (c + cols - 1) % cols : ((c > 0) ? c - 1 : 0);
        if (mv_right) c = cfg_wrap[d] ? (c + 1) % cols : ((c < cols - 1) ? c + 1 : c);
        if (mv_up)    r = cfg_wrap[d] ? (r + rows - 1) % rows : ((r > 0) ? r - 1 : 0);
        if (mv_down)  r = cfg_wrap[d] ? (r + 1) % rows : ((r < rows - 1) ? r + 1 : r);
        m_idx[d] = r * cols + c;
        moved = 1'b1;
      end
      m_err[d] = e;
      m_t[d] = moved ? 0 : m_t[d] + 1;
    end
  endtask

  // Advance one clock; outputs are then observed at the falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mv_left = 0; mv_right = 0; mv_up = 0; mv_down = 0;
    load = 0; load_idx = '0; mark = 0; clear_all = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    enable = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_checks += 5;
      if (pos[d] !== 4'd0) begin n_fail++; $display("FAIL reset_pos dut%0d got %0d expected 0", d, pos[d]); end
      if (oe[d] !== 16'h0001) begin n_fail++; $display("FAIL reset_out_en dut%0d got %h expected 0001", d, oe[d]); end
      if (occ[d] !== 16'h0000) begin n_fail++; $display("FAIL reset_occ dut%0d got %h expected 0000", d, occ[d]); end
      if (full[d] !== 1'b0) begin n_fail++; $display("FAIL reset_full dut%0d got %b expected 0", d, full[d]); end
      if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err dut%0d got %b expected 0", d, err[d]); end
    end
  endtask

  task automatic test_wrap();
    load = 1; load_idx = 4'd3; cycle(); load = 0;
    mv_right = 1; cycle(); mv_right = 0;
    n_checks++;
    if (pos[0] !== 4'd0) begin n_fail++; $display("FAIL wrap_right got %0d expected 0", pos[0]); end
    load = 1; load_idx = 4'd12; cycle(); load = 0;
    mv_down = 1; cycle(); mv_down = 0;
    n_checks++;
    if (pos[0] !== 4'd0) begin n_fail++; $display("FAIL wrap_down got %0d expected 0", pos[0]); end
    mv_left = 1; cycle(); mv_left = 0;
    n_checks++;
    if (pos[0] !== 4'd3) begin n_fail++; $display("FAIL wrap_left got %0d expected 3", pos[0]); end
  endtask

  task automatic test_saturate();
    load = 1; load_idx = 4'd15; cycle(); load = 0;
    mv_right = 1; cycle(); mv_right = 0;
    n_checks += 2;
    if (pos[1] !== 4'd15) begin n_fail++; $display("FAIL sat_right got %0d expected 15", pos[1]); end
    if (err[1] !== 1'b0) begin n_fail++; $display("FAIL sat_right_err got %b expected 0", err[1]); end
    mv_down = 1; cycle(); mv_down = 0;
    n_checks += 2;
    if (pos[1] !== 4'd15) begin n_fail++; $display("FAIL sat_down got %0d expected 15", pos[1]); end
    if (err[1] !== 1'b0) begin n_fail++; $display("FAIL sat_down_err got %b expected 0", err[1]); end
    load = 1; load_idx = 4'd0; cycle(); load = 0;
    mv_up = 1; cycle(); mv_up = 0;
    n_checks++;
    if (pos[1] !== 4'd0) begin n_fail++; $display("FAIL sat_up got %0d expected 0", pos[1]); end
  endtask

  task automatic test_load();
    load = 1; load_idx = 4'd9; cycle(); load = 0;
    n_checks += 2;
    if (oe[0] !== 16'h0200) begin n_fail++; $display("FAIL load9_out_en dut0 got %h expected 0200", oe[0]); end
    if (oe[2] !== 16'h0200) begin n_fail++; $display("FAIL load9_out_en dut2 got %h expected 0200", oe[2]); end
    load = 1; load_idx = 4'd15; cycle(); load = 0;
    n_checks += 4;
    if (pos[2] !== 4'd9) begin n_fail++; $display("FAIL load_oob_pos got %0d expected 9", pos[2]); end
    if (err[2] !== 1'b1) begin n_fail++; $display("FAIL load_oob_err got %b expected 1", err[2]); end
    if (pos[0] !== 4'd15) begin n_fail++; $display("FAIL load15_pos dut0 got %0d expected 15", pos[0]); end
    if (err[0] !== 1'b0) begin n_fail++; $display("FAIL load15_err dut0 got %b expected 0", err[0]); end
    cycle();
    n_checks++;
    if (err[2] !== 1'b0) begin n_fail++; $display("FAIL load_oob_err_clear got %b expected 0", err[2]); end
    mv_left = 1; mv_right = 1; cycle(); mv_left = 0; mv_right = 0;
    n_checks += 3;
    if (pos[0] !== 4'd15) begin n_fail++; $display("FAIL dual_move dut0 got %0d expected 15", pos[0]); end
    if (pos[2] !== 4'd9) begin n_fail++; $display("FAIL dual_move dut2 got %0d expected 9", pos[2]); end
    if (err[2] !== 1'b0) begin n_fail++; $display("FAIL dual_move_err got %b expected 0", err[2]); end
  endtask

  task automatic test_mark();
    load = 1; load_idx = 4'd5; cycle(); load = 0;
    mark = 1; cycle();
    n_checks += 2;
    if (occ[0] !== 16'h0020) begin n_fail++; $display("FAIL mark_first_occ got %h expected 0020", occ[0]); end
    if (err[0] !== 1'b0) begin n_fail++; $display("FAIL mark_first_err got %b expected 0", err[0]); end
    cycle(); mark = 0;
    n_checks += 2;
    if (occ[0] !== 16'h0020) begin n_fail++; $display("FAIL mark_again_occ got %h expected 0020", occ[0]); end
    if (err[0] !== 1'b1) begin n_fail++; $display("FAIL mark_again_err got %b expected 1", err[0]); end
    for (int i = 0; i < 16; i++) begin
      load = 1; load_idx = 4'(i); cycle(); load = 0;
      mark = 1; cycle(); mark = 0;
    end
    n_checks++;
    if (occ[0] !== 16'hFFFF) begin n_fail++; $display("FAIL fill_occ got %h expected ffff", occ[0]); end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (full[d] !== 1'b1) begin n_fail++; $display("FAIL fill_full dut%0d got %b expected 1", d, full[d]); end
    end
    clear_all = 1; mark = 1; cycle(); clear_all = 0; mark = 0;
    for (int d = 0; d < 3; d++) begin
      n_checks += 3;
      if (occ[d] !== 16'h0000) begin n_fail++; $display("FAIL clear_mark_occ dut%0d got %h expected 0000", d, occ[d]); end
      if (err[d] !== 1'b0) begin n_fail++; $display("FAIL clear_mark_err dut%0d got %b expected 0", d, err[d]); end
      if (full[d] !== 1'b0) begin n_fail++; $display("FAIL clear_mark_full dut%0d got %b expected 0", d, full[d]); end
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    cycle();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (oe[d] !== 16'h0000) begin n_fail++; $display("FAIL enable_off dut%0d got %h expected 0000", d, oe[d]); end
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst       = ($urandom_range(0, 49) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      load      = ($urandom_range(0, 4) == 0);
      load_idx  = 4'($urandom_range(0, 15));
      mv_left   = ($urandom_range(0, 2) == 0);
      mv_right  = ($urandom_range(0, 2) == 0);
      mv_up     = ($urandom_range(0, 2) == 0);
      mv_down   = ($urandom_range(0, 2) == 0);
      mark      = ($urandom_range(0, 3) == 0);
      clear_all = ($urandom_range(0, 19) == 0);
      cycle();
      for (int d = 0; d < 3; d++) begin
        n_checks += 5;
        if (pos[d] !== 4'(m_idx[d])) begin n_fail++; $display("FAIL rand_pos dut%0d cycle %0d got %0d expected %0d", d, cyc, pos[d], m_idx[d]); end
        if (oe[d] !== exp_oe(d)) begin n_fail++; $display("FAIL rand_out_en dut%0d cycle %0d got %h expected %h", d, cyc, oe[d], exp_oe(d)); end
        if (occ[d] !== m_occ[d]) begin n_fail++; $display("FAIL rand_occ dut%0d cycle %0d got %h expected %h", d, cyc, occ[d], m_occ[d]); end
        if (full[d] !== (m_occ[d] == full_mask(d))) begin n_fail++; $display("FAIL rand_full dut%0d cycle %0d got %b expected %b", d, cyc, full[d], (m_occ[d] == full_mask(d))); end
        if (err[d] !== m_err[d]) begin n_fail++; $display("FAIL rand_err dut%0d cycle %0d got %b expected %b", d, cyc, err[d], m_err[d]); end
      end
    end
    rst = 1'b0;
    idle_inputs();
    enable = 1'b1;
  endtask

`ifdef POSITION_CURSOR_BLINK_EN
  task automatic test_blink();
    idle_inputs();
    enable = 1'b1;
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (oe[0] !== ((k < BDIV) ? 16'h0001 : 16'h0000)) begin
        n_fail++; $display("FAIL blink_phase k=%0d got %h expected %h", k, oe[0], ((k < BDIV) ? 16'h0001 : 16'h0000));
      end
      cycle();
    end
    repeat (5) cycle();
    n_checks++;
    if (oe[0] !== 16'h0000) begin n_fail++; $display("FAIL blink_off_before_move got %h expected 0000", oe[0]); end
    mv_right = 1; cycle(); mv_right = 0;
    n_checks++;
    if (oe[0] !== 16'h0002) begin n_fail++; $display("FAIL blink_move_restart got %h expected 0002", oe[0]); end
    enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      n_checks++;
      if (oe[0] !== 16'h0000) begin n_fail++; $display("FAIL blink_disabled k=%0d got %h expected 0000", k, oe[0]); end
    end
    enable = 1'b1;
  endtask
`endif

  initial begin
    idle_inputs();
    rst = 1'b1;
    enable = 1'b1;
    test_reset();
    $display("test_reset done: %0d checks, %0d failures", n_checks, n_fail);
    test_wrap();
    $display("test_wrap done: %0d checks, %0d failures", n_checks, n_fail);
    test_saturate();
    $display("test_saturate done: %0d checks, %0d failures", n_checks, n_fail);
    test_load();
    $display("test_load done: %0d checks, %0d failures", n_checks, n_fail);
    test_mark();
    $display("test_mark done: %0d checks, %0d failures", n_checks, n_fail);
    test_enable();
    $display("test_enable done: %0d checks, %0d failures", n_checks, n_fail);
    test_random();
    $display("test_random done: %0d checks, %0d failures", n_checks, n_fail);
`ifdef POSITION_CURSOR_BLINK_EN
    test_blink();
    $display("test_blink done: %0d checks, %0d failures", n_checks, n_fail);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
